// File: rtl/input_debounce_sync.sv
// -----------------------------------------------------------------------------
// input_debounce_sync
//
// Conditions a raw asynchronous, possibly bouncing single-bit input for the
// downstream D flip-flop test stage. The input passes through a plain flop
// synchronizer chain. A two-state debounce FSM then accepts a new level only
// after it has been seen on the last synchronizer stage for DEBOUNCE_CYCLES
// consecutive clocks.
//
// Ports
//   clk            : single clock, rising edge
//   async_reset_n  : asynchronous active-low reset, highest priority
//   sync_reset     : synchronous active-high clear, sampled on clk
//   i_value        : raw asynchronous input
//   o_value        : debounced, synchronized level
//   o_rise         : one-cycle strobe, coincident with o_value going 0->1
//   o_fall         : one-cycle strobe, coincident with o_value going 1->0
//   o_busy         : high while a candidate level is being qualified
// -----------------------------------------------------------------------------
module input_debounce_sync #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter int   CNT_W           = 8,
   parameter logic RESET_VALUE     = 1'b0
) (
   input  logic clk,
   input  logic async_reset_n,
   input  logic sync_reset,
   input  logic i_value,
   output logic o_value,
   output logic o_rise,
   output logic o_fall,
   output logic o_busy
);

   typedef enum logic {
      STABLE = 1'b0,
      CHECK  = 1'b1
   } state_t;

   // Commit happens when the counter already holds DEBOUNCE_CYCLES-1.
   // Entering CHECK counts as the first sample.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   value_q, value_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   s;

   // Synchronizer: a straight shift chain. Only the clear mux sits in front of
   // the flops. No logic sits between stages.
   always_comb begin
      if (sync_reset) begin
         sync_d = {SYNC_STAGES{RESET_VALUE}};
      end else begin
         sync_d = {sync_q[SYNC_STAGES-2:0], i_value};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // Debounce FSM: next state, counter, level and strobes
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      if (sync_reset) begin
         state_d = STABLE;
         cnt_d   = '0;
         value_d = RESET_VALUE;
      end else begin
         case (state_q)
            STABLE: begin
               if (s != value_q) begin
                  state_d = CHECK;
                  cnt_d   = CNT_W'(1);
               end
            end
            CHECK: begin
               if (s == value_q) begin
                  // Glitch: drop all partial credit.
                  state_d = STABLE;
                  cnt_d   = '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_d = STABLE;
                  cnt_d   = '0;
                  value_d = s;
                  rise_d  = s;
                  fall_d  = ~s;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = STABLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         sync_q  <= {SYNC_STAGES{RESET_VALUE}};
         state_q <= STABLE;
         cnt_q   <= '0;
         value_q <= RESET_VALUE;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign o_value = value_q;
   assign o_rise  = rise_q;
   assign o_fall  = fall_q;
   assign o_busy  = (state_q == CHECK);

endmodule

// File: tb/tb_input_debounce_sync.sv
// -----------------------------------------------------------------------------
// tb_input_debounce_sync
//
// Testbench for input_debounce_sync. It uses two instances:
//   u_dut  : default parameters (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
//   u_dut2 : SYNC_STAGES=3, DEBOUNCE_CYCLES=2
//
// Stimulus is held in run-length tables. Each record gives the inputs, the
// number of edges to hold them, and the outputs expected after each of those
// edges. Expected values are queued as each edge is driven and compared after
// the edge.
// -----------------------------------------------------------------------------
module tb_input_debounce_sync;

   logic clk = 1'b0;
   logic rst_n, srst, din;
   logic o_value, o_rise, o_fall, o_busy;
   logic rst2_n, srst2, din2;
   logic o2_value, o2_rise, o2_fall, o2_busy;

   always #5 clk = ~clk;

   input_debounce_sync u_dut (
      .clk(clk), .async_reset_n(rst_n), .sync_reset(srst), .i_value(din),
      .o_value(o_value), .o_rise(o_rise), .o_fall(o_fall), .o_busy(o_busy));

   input_debounce_sync #(.SYNC_STAGES(3), .DEBOUNCE_CYCLES(2)) u_dut2 (
      .clk(clk), .async_reset_n(rst2_n), .sync_reset(srst2), .i_value(din2),
      .o_value(o2_value), .o_rise(o2_rise), .o_fall(o2_fall), .o_busy(o2_busy));

   typedef struct {
      logic in;
      logic sr;
      int   n;
      logic o, r, f, b;
   } vec_t;

   typedef struct {
      int   idx;
      logic o, r, f, b;
   } exp_t;

   vec_t tab[$];
   vec_t tab2[$];
   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input int idx, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%b exp=%b", name, idx, act, exp);
      end
   endtask

   // Drive one table, one edge at a time. Each edge's expectations are queued
   // before the edge and popped after it.
   task automatic run_table(input int sel);
      int nvec;
      exp_t e;
      vec_t v;
      nvec = (sel == 0) ? tab.size() : tab2.size();
      for (int k = 0; k < nvec; k++) begin
         v = (sel == 0) ? tab[k] : tab2[k];
         for (int c = 0; c < v.n; c++) begin
            @(negedge clk);
            if (sel == 0) begin
               din  = v.in;
               srst = v.sr;
            end else begin
               din2  = v.in;
               srst2 = v.sr;
            end
            sb.push_back('{idx: k, o: v.o, r: v.r, f: v.f, b: v.b});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            if (sel == 0) begin
               chk("o_value", e.idx, o_value, e.o);
               chk("o_rise",  e.idx, o_rise,  e.r);
               chk("o_fall",  e.idx, o_fall,  e.f);
               chk("o_busy",  e.idx, o_busy,  e.b);
            end else begin
               chk("p_o_value", e.idx, o2_value, e.o);
               chk("p_o_rise",  e.idx, o2_rise,  e.r);
               chk("p_o_fall",  e.idx, o2_fall,  e.f);
               chk("p_o_busy",  e.idx, o2_busy,  e.b);
            end
            $display("vec sel=%0d idx=%0d in=%b sr=%b o=%b r=%b f=%b b=%b",
                     sel, e.idx, v.in, v.sr, e.o, e.r, e.f, e.b);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      // Columns: in, sync_reset, edges, o_value, o_rise, o_fall, o_busy.
      // Clean rise and clean fall.
      tab.push_back('{1, 0, 2, 0, 0, 0, 0});
      tab.push_back('{1, 0, 3, 0, 0, 0, 1});
      tab.push_back('{1, 0, 1, 1, 1, 0, 0});
      tab.push_back('{1, 0, 2, 1, 0, 0, 0});
      tab.push_back('{0, 0, 2, 1, 0, 0, 0});
      tab.push_back('{0, 0, 3, 1, 0, 0, 1});
      tab.push_back('{0, 0, 1, 0, 0, 1, 0});
      tab.push_back('{0, 0, 2, 0, 0, 0, 0});
      // 3-cycle glitch is rejected.
      tab.push_back('{1, 0, 2, 0, 0, 0, 0});
      tab.push_back('{1, 0, 1, 0, 0, 0, 1});
      tab.push_back('{0, 0, 2, 0, 0, 0, 1});
      tab.push_back('{0, 0, 5, 0, 0, 0, 0});
      // A 4-cycle pulse is accepted, then falls back.
      tab.push_back('{1, 0, 2, 0, 0, 0, 0});
      tab.push_back('{1, 0, 2, 0, 0, 0, 1});
      tab.push_back('{0, 0, 1, 0, 0, 0, 1});
      tab.push_back('{0, 0, 1, 1, 1, 0, 0});
      tab.push_back('{0, 0, 3, 1, 0, 0, 1});
      tab.push_back('{0, 0, 1, 0, 0, 1, 0});
      tab.push_back('{0, 0, 4, 0, 0, 0, 0});
      // Re-toggle: s returns on the cnt==3 edge, then a full 4-cycle requalification.
      tab.push_back('{1, 0, 2, 0, 0, 0, 0});
      tab.push_back('{1, 0, 1, 0, 0, 0, 1});
      tab.push_back('{0, 0, 1, 0, 0, 0, 1});
      tab.push_back('{1, 0, 1, 0, 0, 0, 1});
      tab.push_back('{1, 0, 1, 0, 0, 0, 0});
      tab.push_back('{1, 0, 3, 0, 0, 0, 1});
      tab.push_back('{1, 0, 1, 1, 1, 0, 0});
      tab.push_back('{1, 0, 2, 1, 0, 0, 0});
      // sync_reset at cnt==2 while falling, then a full 6-edge rise.
      tab.push_back('{0, 0, 2, 1, 0, 0, 0});
      tab.push_back('{0, 0, 2, 1, 0, 0, 1});
      tab.push_back('{0, 1, 1, 0, 0, 0, 0});
      tab.push_back('{1, 0, 2, 0, 0, 0, 0});
      tab.push_back('{1, 0, 3, 0, 0, 0, 1});
      tab.push_back('{1, 0, 1, 1, 1, 0, 0});
      tab.push_back('{1, 0, 1, 1, 0, 0, 0});
      // Enter CHECK on a fall so the async-reset abort can be checked.
      tab.push_back('{0, 0, 2, 1, 0, 0, 0});
      tab.push_back('{0, 0, 1, 1, 0, 0, 1});

      // Parameter sweep: SYNC_STAGES=3, DEBOUNCE_CYCLES=2 commits after edge 5.
      tab2.push_back('{1, 0, 3, 0, 0, 0, 0});
      tab2.push_back('{1, 0, 1, 0, 0, 0, 1});
      tab2.push_back('{1, 0, 1, 1, 1, 0, 0});
      tab2.push_back('{1, 0, 2, 1, 0, 0, 0});

      // Reset check: outputs clear before any clk edge, even with i_value=1.
      rst_n  = 1'b0;
      srst   = 1'b0;
      din    = 1'b1;
      rst2_n = 1'b0;
      srst2  = 1'b0;
      din2   = 1'b0;
      #2;
      chk("rst_o_value", 0, o_value, 1'b0);
      chk("rst_o_rise",  0, o_rise,  1'b0);
      chk("rst_o_fall",  0, o_fall,  1'b0);
      chk("rst_o_busy",  0, o_busy,  1'b0);
      $display("reset: o=%b r=%b f=%b b=%b", o_value, o_rise, o_fall, o_busy);
      #8;
      @(posedge clk);
      #1;
      chk("rst_hold_o_value", 0, o_value, 1'b0);
      @(negedge clk);
      din    = 1'b0;
      rst_n  = 1'b1;
      rst2_n = 1'b1;

      run_table(0);

      // Async reset between edges while in CHECK.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("arst_o_value", 0, o_value, 1'b0);
      chk("arst_o_rise",  0, o_rise,  1'b0);
      chk("arst_o_fall",  0, o_fall,  1'b0);
      chk("arst_o_busy",  0, o_busy,  1'b0);
      $display("async reset mid-CHECK: o=%b r=%b f=%b b=%b", o_value, o_rise, o_fall, o_busy);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("arst_rel_o_value", 0, o_value, 1'b0);
      chk("arst_rel_o_fall",  0, o_fall,  1'b0);
      chk("arst_rel_o_busy",  0, o_busy,  1'b0);
      $display("async reset release: o=%b f=%b b=%b", o_value, o_fall, o_busy);

      run_table(1);

      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
